// File: rtl/envelope_pkg.sv
// Shared widths, types and default shift constants for the envelope channel scheduler.
package envelope_pkg;

   localparam int SAMPLE_W = 24;
   localparam int ACC_W    = 32;
   localparam int LEVEL_W  = 6;

   localparam int IN_SHIFT_DEF     = 8;
   localparam int DECAY_SHIFT_DEF  = 10;
   localparam int SCALE_SHIFT_DEF  = 18;
   localparam int SMOOTH_SHIFT_DEF = 3;

   typedef logic signed [SAMPLE_W-1:0] sample_t;
   typedef logic [ACC_W-1:0]           acc_t;
   typedef logic [LEVEL_W-1:0]         level_t;

   function automatic int ch_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // |-2^23| is representable as the unsigned magnitude 0x800000.
   function automatic acc_t abs_scaled(input sample_t s, input int shift);
      logic [SAMPLE_W-1:0] mag;
      mag = s[SAMPLE_W-1] ? $unsigned(-s) : $unsigned(s);
      return ACC_W'(mag >> shift);
   endfunction

endpackage

// File: rtl/envelope_channel_scheduler_if.sv
// Sample handshake and level output bundle; names follow the scheduler's point of view.
interface envelope_channel_scheduler_if
   import envelope_pkg::*;
#(
   parameter int NUM_CH = 4
);

   localparam int CH_W = ch_width(NUM_CH);

   logic [NUM_CH-1:0]          sample_valid_i;
   logic [NUM_CH*SAMPLE_W-1:0] sample_i;
   logic [NUM_CH-1:0]          sample_ready_o;
   logic [NUM_CH*LEVEL_W-1:0]  level_o;
   logic                       level_valid_o;
   logic [CH_W-1:0]            level_ch_o;

   modport master (
      output sample_valid_i,
      output sample_i,
      input  sample_ready_o,
      input  level_o,
      input  level_valid_o,
      input  level_ch_o
   );

   modport slave (
      input  sample_valid_i,
      input  sample_i,
      output sample_ready_o,
      output level_o,
      output level_valid_o,
      output level_ch_o
   );

endinterface

// File: rtl/envelope_rr_arbiter.sv
// Round-robin arbiter with a per-requester mask; searches ptr+1, ptr+2, ... modulo N.
module envelope_rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req_i,
   input  logic [N-1:0]     mask_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o
);

   always_comb begin
      logic [IDX_W-1:0] c;
      c       = '0;
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      for (int off = 1; off <= N; off++) begin
         c = IDX_W'((int'(ptr_i) + off) % N);
         if (!valid_o && req_i[c] && !mask_i[c]) begin
            valid_o  = 1'b1;
            gnt_o[c] = 1'b1;
            idx_o    = c;
         end
      end
   end

endmodule

// File: rtl/envelope_channel_scheduler.sv
// Shares one envelope/level update datapath across NUM_CH channels via a round-robin
// grant followed by a single update stage.
module envelope_channel_scheduler
   import envelope_pkg::*;
#(
   parameter int NUM_CH       = 4,
   parameter int IN_SHIFT     = IN_SHIFT_DEF,
   parameter int DECAY_SHIFT  = DECAY_SHIFT_DEF,
   parameter int SCALE_SHIFT  = SCALE_SHIFT_DEF,
   parameter int SMOOTH_SHIFT = SMOOTH_SHIFT_DEF
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         enable_i,
   input  logic                         clear_i,
   envelope_channel_scheduler_if.slave  bus
);

   localparam int CH_W = ch_width(NUM_CH);

   logic [NUM_CH-1:0] req;
   logic [NUM_CH-1:0] mask;
   logic [NUM_CH-1:0] gnt;
   logic [CH_W-1:0]   gnt_idx;
   logic              xfer;
   sample_t           sample_sel;

   logic [CH_W-1:0]   ptr_q, ptr_d;
   logic              s1_valid_q, s1_valid_d;
   logic [CH_W-1:0]   s1_ch_q, s1_ch_d;
   acc_t              s1_abs_q, s1_abs_d;
   logic              level_valid_q, level_valid_d;
   logic [CH_W-1:0]   level_ch_q, level_ch_d;

   acc_t              acc_q   [NUM_CH];
   level_t            level_q [NUM_CH];

   acc_t              acc_old, acc_new, lvl_wide;
   level_t            lvl_raw, lvl_old, lvl_new;

   // The channel sitting in the update stage is masked so its accumulator is never
   // read before the pending write lands.
   assign req = bus.sample_valid_i & {NUM_CH{enable_i & ~clear_i}};

   always_comb begin
      mask = '0;
      if (s1_valid_q) mask[s1_ch_q] = 1'b1;
   end

   envelope_rr_arbiter #(
      .N     (NUM_CH),
      .IDX_W (CH_W)
   ) u_arb (
      .req_i   (req),
      .mask_i  (mask),
      .ptr_i   (ptr_q),
      .gnt_o   (gnt),
      .idx_o   (gnt_idx),
      .valid_o (xfer)
   );

   assign bus.sample_ready_o = gnt;
   assign sample_sel         = bus.sample_i[gnt_idx*SAMPLE_W +: SAMPLE_W];

   always_comb begin
      ptr_d         = ptr_q;
      s1_ch_d       = s1_ch_q;
      s1_abs_d      = s1_abs_q;
      s1_valid_d    = xfer;
      level_valid_d = s1_valid_q;
      level_ch_d    = level_ch_q;
      if (xfer) begin
         ptr_d    = gnt_idx;
         s1_ch_d  = gnt_idx;
         s1_abs_d = abs_scaled(sample_sel, IN_SHIFT);
      end
      if (s1_valid_q) level_ch_d = s1_ch_q;
   end

   // Level is derived from the accumulator value before this update.
   always_comb begin
      acc_old  = acc_q[s1_ch_q];
      acc_new  = acc_old - (acc_old >> DECAY_SHIFT) + s1_abs_q;
      lvl_wide = acc_old >> SCALE_SHIFT;
      lvl_raw  = (|lvl_wide[ACC_W-1:LEVEL_W]) ? '1 : lvl_wide[LEVEL_W-1:0];
      lvl_old  = level_q[s1_ch_q];
      lvl_new  = lvl_old - (lvl_old >> SMOOTH_SHIFT) + (lvl_raw >> SMOOTH_SHIFT);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q         <= CH_W'(NUM_CH - 1);
         s1_valid_q    <= 1'b0;
         s1_ch_q       <= '0;
         s1_abs_q      <= '0;
         level_valid_q <= 1'b0;
         level_ch_q    <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            acc_q[c]   <= '0;
            level_q[c] <= '0;
         end
      end else if (clear_i) begin
         s1_valid_q    <= 1'b0;
         level_valid_q <= 1'b0;
         for (int c = 0; c < NUM_CH; c++) begin
            acc_q[c]   <= '0;
            level_q[c] <= '0;
         end
      end else begin
         ptr_q         <= ptr_d;
         s1_valid_q    <= s1_valid_d;
         s1_ch_q       <= s1_ch_d;
         s1_abs_q      <= s1_abs_d;
         level_valid_q <= level_valid_d;
         level_ch_q    <= level_ch_d;
         if (s1_valid_q) begin
            acc_q[s1_ch_q]   <= acc_new;
            level_q[s1_ch_q] <= lvl_new;
         end
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_level
      assign bus.level_o[c*LEVEL_W +: LEVEL_W] = level_q[c];
   end

   assign bus.level_valid_o = level_valid_q;
   assign bus.level_ch_o    = level_ch_q;

endmodule

// File: tb/tb_envelope_channel_scheduler.sv
// Directed bench: arbitration vector table plus hand sequences for latency, saturation and clear.
module tb_envelope_channel_scheduler;
   import envelope_pkg::*;

   localparam int NUM_CH = 4;

   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   logic enable_i;
   logic clear_i;

   always #5 clk_i = ~clk_i;

   envelope_channel_scheduler_if #(.NUM_CH(NUM_CH)) bus ();

   envelope_channel_scheduler #(.NUM_CH(NUM_CH)) dut (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .enable_i (enable_i),
      .clear_i  (clear_i),
      .bus      (bus)
   );

   int total  = 0;
   int passed = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   typedef struct {
      logic [3:0] valid;
      logic       en;
      logic       clr;
      logic [3:0] exp_rdy;
      logic       exp_lv;
      logic [1:0] exp_lch;
   } vec_t;

   vec_t vecs [19];

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      int        xfers;
      int        cyc;
      bit        mono;
      logic [5:0] prev, cur;

      //           valid    en    clr   rdy      lv    lch
      vecs[0]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b0, 2'd0};
      vecs[1]  = '{4'b1111, 1'b1, 1'b0, 4'b0010, 1'b0, 2'd0};
      vecs[2]  = '{4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd0};
      vecs[3]  = '{4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd1};
      vecs[4]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd2};
      vecs[5]  = '{4'b0001, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd3};
      vecs[6]  = '{4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0};
      vecs[7]  = '{4'b0001, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0};
      vecs[8]  = '{4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0};
      vecs[9]  = '{4'b1111, 1'b1, 1'b0, 4'b0010, 1'b0, 2'd0};
      vecs[10] = '{4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
      vecs[11] = '{4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd1};
      vecs[12] = '{4'b1010, 1'b1, 1'b0, 4'b1000, 1'b0, 2'd0};
      vecs[13] = '{4'b1010, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd2};
      vecs[14] = '{4'b1010, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd3};
      vecs[15] = '{4'b1111, 1'b1, 1'b1, 4'b0000, 1'b1, 2'd1};
      vecs[16] = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b0, 2'd0};
      vecs[17] = '{4'b0100, 1'b1, 1'b0, 4'b0100, 1'b0, 2'd0};
      vecs[18] = '{4'b0100, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd0};

      bus.sample_valid_i = '0;
      bus.sample_i       = '0;
      enable_i           = 1'b1;
      clear_i            = 1'b0;

      // Reset state
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_level", bus.level_o, 0);
      check("rst_level_valid", bus.level_valid_o, 0);
      check("rst_level_ch", bus.level_ch_o, 0);
      check("rst_ready", bus.sample_ready_o, 0);
      @(negedge clk_i) rst_ni = 1'b1;
      next_cycle();

      // Single max-positive sample on ch0: latency and first accumulator value
      bus.sample_valid_i = 4'b0001;
      bus.sample_i[23:0] = 24'h7FFFFF;
      @(negedge clk_i);
      check("a_ready", bus.sample_ready_o, 4'b0001);
      next_cycle();
      bus.sample_valid_i = '0;
      @(negedge clk_i);
      check("a_lv_early", bus.level_valid_o, 0);
      @(negedge clk_i);
      check("a_lv", bus.level_valid_o, 1);
      check("a_lch", bus.level_ch_o, 0);
      check("a_level0", bus.level_o[5:0], 0);
      check("a_acc0", dut.acc_q[0], 32767);

      // Asynchronous reset mid-operation
      rst_ni = 1'b0;
      #1;
      check("arst_lv", bus.level_valid_o, 0);
      check("arst_acc0", dut.acc_q[0], 0);
      @(negedge clk_i) rst_ni = 1'b1;
      next_cycle();

      // ch1 held at the most negative sample: level rises monotonically and settles at 56
      bus.sample_valid_i   = 4'b0010;
      bus.sample_i[47:24]  = 24'h800000;
      xfers = 0;
      cyc   = 0;
      mono  = 1'b1;
      prev  = '0;
      while (xfers < 20000 && cyc < 50000) begin
         @(negedge clk_i);
         if (bus.sample_ready_o[1]) xfers++;
         cur = bus.level_o[11:6];
         if (cur < prev) mono = 1'b0;
         prev = cur;
         cyc++;
      end
      check("sat_xfer_count", xfers, 20000);
      next_cycle();
      bus.sample_valid_i = '0;
      repeat (3) @(negedge clk_i);
      check("sat_monotonic", {31'd0, mono}, 1);
      check("sat_level1", bus.level_o[11:6], 56);
      check("sat_acc_floor", {31'd0, (dut.acc_q[1] >= 32'h0200_0000)}, 1);
      check("sat_acc_ceil", {31'd0, (dut.acc_q[1] < 32'h0200_0400)}, 1);

      // clear while ch3 is in the update stage
      next_cycle();
      bus.sample_valid_i   = 4'b1000;
      bus.sample_i[95:72]  = 24'h7FFFFF;
      @(negedge clk_i);
      check("clr_ready_ch3", bus.sample_ready_o, 4'b1000);
      next_cycle();
      bus.sample_valid_i = 4'b1111;
      clear_i            = 1'b1;
      @(negedge clk_i);
      check("clr_ready_during", bus.sample_ready_o, 0);
      next_cycle();
      clear_i = 1'b0;
      @(negedge clk_i);
      check("clr_levels", bus.level_o, 0);
      check("clr_acc1", dut.acc_q[1], 0);
      check("clr_lv", bus.level_valid_o, 0);
      check("clr_ptr_resume", bus.sample_ready_o, 4'b0001);
      next_cycle();
      bus.sample_valid_i = '0;
      @(negedge clk_i);
      check("clr_no_ch3_pulse", bus.level_valid_o, 0);

      // Arbitration table from a fresh reset
      rst_ni = 1'b0;
      next_cycle();
      @(negedge clk_i) rst_ni = 1'b1;
      next_cycle();
      bus.sample_i = '0;
      for (int k = 0; k < 19; k++) begin
         bus.sample_valid_i = vecs[k].valid;
         enable_i           = vecs[k].en;
         clear_i            = vecs[k].clr;
         @(negedge clk_i);
         check($sformatf("tbl%0d_ready", k), bus.sample_ready_o, vecs[k].exp_rdy);
         check($sformatf("tbl%0d_lv", k), bus.level_valid_o, vecs[k].exp_lv);
         if (vecs[k].exp_lv) check($sformatf("tbl%0d_lch", k), bus.level_ch_o, vecs[k].exp_lch);
         next_cycle();
      end

      // Only ch2 requesting: grants and pulses on alternate cycles
      bus.sample_valid_i = 4'b0100;
      enable_i           = 1'b1;
      clear_i            = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_i);
         check($sformatf("ch2_ready%0d", i), bus.sample_ready_o, (i % 2 == 0) ? 4'b0100 : 4'b0000);
         check($sformatf("ch2_lv%0d", i), bus.level_valid_o, (i % 2 == 0) ? 1 : 0);
         next_cycle();
      end
      bus.sample_valid_i = '0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
